// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a valid/ready TX FIFO and runtime frame config.
//
// Ports:
//   i_clk_sys     system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_baud_div    system clocks per UART bit (0 and 1 behave as 2)
//   i_parity_en   append a parity bit
//   i_parity_odd  1 = odd parity, 0 = even parity
//   i_stop2       1 = two stop bits, 0 = one stop bit
//   i_data        word to queue
//   i_valid       i_data is valid
//   o_ready       FIFO can accept a word
//   o_fifo_level  words waiting in the FIFO (not counting the one being shifted)
//   o_busy        a frame is in progress
//   o_frame_done  one-cycle pulse at the end of each frame
//   o_uart_tx     registered serial line, idles high
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        i_clk_sys,
    input  logic                        i_rst_n,
    input  logic [DIV_WIDTH-1:0]        i_baud_div,
    input  logic                        i_parity_en,
    input  logic                        i_parity_odd,
    input  logic                        i_stop2,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [LW-1:0]         r_level;
    logic                  r_ready;
    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par;
    logic                  r_stop2;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_uart_tx;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic [LW-1:0]         w_level_nxt;
    logic [DIV_WIDTH-1:0]  w_div;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_push      = i_valid && r_ready;
    assign w_bit_end   = (r_cnt == r_div - DIV_WIDTH'(1));
    // Final cycle of the last stop bit: r_bit counts stop bits (0, then 1 if two)
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit == BW'(r_stop2));
    assign w_pop       = ((r_state == S_IDLE) || w_last_stop) && (r_level != '0);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_div       = (i_baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_baud_div;
    assign w_head      = r_mem[r_rptr];

    assign o_ready      = r_ready;
    assign o_fifo_level = r_level;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_uart_tx    = r_uart_tx;

    // Storage is not reset; the pointers alone define the FIFO contents.
    always_ff @(posedge i_clk_sys) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt < LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_div        <= DIV_WIDTH'(2);
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par        <= 1'b0;
            r_stop2      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_uart_tx    <= 1'b1;
        end else begin
            r_cnt        <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_cnt + DIV_WIDTH'(1);
            r_frame_done <= w_last_stop;
            // The line lags the FSM by one cycle, so the pop edge itself still shows idle
            r_uart_tx    <= (r_state == S_START)  ? 1'b0 :
                            (r_state == S_DATA)   ? r_shift[0] :
                            (r_state == S_PARITY) ? r_par : 1'b1;
            if (w_pop) begin
                r_state  <= S_START;
                r_bit    <= '0;
                r_shift  <= w_head;
                r_div    <= w_div;
                r_par_en <= i_parity_en;
                r_par    <= (^w_head) ^ i_parity_odd;
                r_stop2  <= i_stop2;
                r_busy   <= 1'b1;
            end else if (w_last_stop) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else if (w_bit_end && (r_state != S_IDLE)) begin
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                    end
                    S_DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == BW'(DATA_WIDTH - 1)) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_bit   <= '0;
                    end
                    S_STOP:  r_bit <= r_bit + BW'(1);
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that replaces the single-word transmitter. It has a built-in TX FIFO with a valid/ready write handshake, and its data width, parity mode, stop-bit count and baud divisor are set at runtime. It sits between the SPI-master control logic and the UART pin, so bytes can be queued back-to-back without the host polling an idle flag. Frames are sent LSB first, one start bit, with no idle gap between queued frames.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
DIV_WIDTH, 16, width of the runtime baud divisor.

Ports:
i_clk_sys  in  1  system clock; all logic is on the rising edge.
i_rst_n  in  1  reset, asynchronous, active-low.
i_baud_div  in  DIV_WIDTH  system clocks per UART bit; values 0 and 1 are treated as 2.
i_parity_en  in  1  1 = append a parity bit.
i_parity_odd  in  1  1 = odd parity, 0 = even parity.
i_stop2  in  1  1 = two stop bits, 0 = one stop bit.
i_data  in  DATA_WIDTH  word to queue.
i_valid  in  1  i_data is valid.
o_ready  out  1  FIFO can accept a word.
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words resident in the FIFO, excluding the word in the shifter.
o_busy  out  1  a frame is in progress.
o_frame_done  out  1  one-cycle pulse at the end of each frame.
o_uart_tx  out  1  serial line; registered; idles high.

Behaviour:
- Reset (asynchronous): o_uart_tx=1, o_ready=1, o_fifo_level=0, o_busy=0, o_frame_done=0, FIFO empty, FSM in IDLE, baud counter 0.
- Write handshake: a word is accepted on a rising edge with i_valid&&o_ready.
  - o_ready = (o_fifo_level < FIFO_DEPTH), registered from the level.
  - i_valid while o_ready=0 is ignored; no overflow, no data loss.
  - A push and a pop in the same cycle leave the level unchanged.
- Pop and config latch: the FSM pops only in IDLE, or in the last cycle of the final stop bit, when the FIFO is non-empty.
  - At the pop it latches the word, i_baud_div (clamped to ≥2), i_parity_en, i_parity_odd and i_stop2.
  - Config changes mid-frame have no effect on that frame.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE:
  - o_fifo_level=1 after edge N.
  - Popped at edge N+1.
  - o_uart_tx=0 (start bit) from edge N+2.
- Baud counter: counts 0..div-1 per bit, so each bit drives o_uart_tx for exactly div cycles. It restarts at 0 on every bit boundary.
- FSM states: IDLE -> START (1 bit) -> DATA (DATA_WIDTH bits, LSB first) -> PARITY (1 bit, only if parity_en) -> STOP (1 or 2 bits) -> IDLE, or directly to START if the FIFO is non-empty at the last stop cycle.
- Frame length: (1 + DATA_WIDTH + parity_en + 1 + stop2) × div cycles.
- Parity bit = XOR of the data bits, inverted when parity_odd=1.
  - Even parity: total number of ones in data+parity is even.
  - Odd parity: total number of ones in data+parity is odd.
- o_busy: 1 from the pop edge until the edge after the last stop cycle of a frame that has no successor queued. It stays 1 continuously across back-to-back frames.
- o_frame_done: one-cycle pulse in the cycle after the last stop-bit cycle of every frame, including back-to-back frames.
- o_fifo_level: decrements at the pop edge and increments at the accept edge.
- Reset mid-frame: o_uart_tx returns high immediately (asynchronous), the FIFO is flushed and the partial frame is discarded.

Test Plan:
- DIV=4, no parity, 1 stop, push 0xA5 -> line = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; 40 cycles total; one o_frame_done pulse; start bit 2 cycles after the accept edge.
- Parity: DIV=4, push 0x07 with parity_en=1 -> even: parity bit 1; odd: parity bit 0; frame is 44 cycles. With stop2=1 and no parity -> 44 cycles, last 8 cycles high.
- Back-to-back: DIV=3, push 0x00 then 0xFF on consecutive cycles -> second start bit immediately follows the first frame's stop bit (zero idle cycles); o_busy stays high throughout; two o_frame_done pulses 30 cycles apart.
- Full FIFO: FIFO_DEPTH=4, DIV=100, hold i_valid high with 6 distinct words -> 5 words accepted (1 in the shifter, 4 in the FIFO); o_ready low with level=4; o_ready rises at the next pop; all 6 words transmitted in order.
- Divisor clamp and mid-frame config change: i_baud_div=0 -> 2 cycles per bit; change i_baud_div from 4 to 8 during the frame -> current frame stays at 4 cycles per bit, next frame uses 8.
- Reset mid-frame: assert i_rst_n low during DATA with 3 words queued -> o_uart_tx=1 immediately; after release level=0, o_busy=0, no further frames sent.
